ex_wideadd_sched: RTL and testbench
===================================

Name: ex_wideadd_sched

Overview:
- Sequencer and arbiter that time-shares one external 64-bit carry-select adder (sum only, no carry-in/out, combinational) between two requesters.
- Supports 64-bit and 128-bit add/subtract. Carry-in and two's-complement are emulated by issuing extra "+1" passes through the same adder.
- Sits beside the EX-stage ALU and serves multi-cycle wide-integer ops, so the adder does not have to be duplicated.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration between requesters; 0 = fixed priority, requester 0 wins.
- SKIP_HINC, 1, 1 = omit the high increment pass when the carry into the high half is 0; 0 = always issue it, adding 0 (fixed latency).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  2  0=ADD64, 1=SUB64, 2=ADD128, 3=SUB128
- req0_a / req1_a  in  128  operand A (64-bit ops use [63:0])
- req0_b / req1_b  in  128  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  index of the requester that owns the result
- rsp_val  out  128  result; [127:64]=0 for 64-bit ops
- rsp_carry  out  1  carry out of the op's top bit (for SUB: 1 = no borrow)
- add_a  out  64  adder operand A
- add_b  out  64  adder operand B
- add_c  in  64  adder sum (add_a+add_b mod 2^64, same cycle)

Behaviour:
- **Reset.** rsp_valid=0, rsp_id=0, rsp_val=0, rsp_carry=0, reqN_ready=0, add_a=add_b=0, state=IDLE, RR pointer=0. Reset mid-operation abandons the op; no response is produced.
- **States.** IDLE, LO, LINC, HI, HINC, DONE.
- **IDLE.**
  - Grant one valid requester. With RR_EN=1, the requester not served last wins a tie; with RR_EN=0, requester 0 wins.
  - The granted reqN_ready pulses 1 for exactly one cycle. Operands, op and id are latched. Next state is LO.
  - ready is never asserted outside IDLE.
- **Adder drive per state.** Each pass takes one cycle. The sum is captured at the end of the pass cycle.
  - LO: a=A[63:0], b = B[63:0] (ADD) or ~B[63:0] (SUB).
  - LINC: a=lo_sum, b=1.
  - HI: a=A[127:64], b = B[127:64] (ADD) or ~B[127:64] (SUB).
  - HINC: a=hi_sum, b = 64'd1 if cin_hi else 0.
  - IDLE/DONE: a=b=0.
- **Pass carry.** c = (a[63]&b[63]) | ((a[63]|b[63]) & ~add_c[63]).
- **Transitions.**
  - ADD64: LO -> DONE. carry = c_LO.
  - SUB64: LO -> LINC -> DONE. carry = c_LO | c_LINC.
  - ADD128: LO -> HI -> (HINC if c_LO, or always if SKIP_HINC=0) -> DONE. cin_hi = c_LO.
  - SUB128: LO -> LINC -> HI -> HINC/skip -> DONE. cin_hi = c_LO | c_LINC.
  - 128-bit final carry = c_HI | c_HINC.
- **Latency from accept to rsp_valid rising.**

  | Op | Cycles |
  |---|---|
  | ADD64 | 2 |
  | SUB64 | 3 |
  | ADD128 | 3 without HINC, 4 with HINC |
  | SUB128 | 4 without HINC, 5 with HINC |

- **DONE.**
  - rsp_valid=1 and rsp_* are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, the next state is IDLE and the RR pointer is updated to the served id.
  - A new grant may happen in the IDLE cycle immediately following, so there is at least 1 idle cycle between responses.
  - rsp_ready while rsp_valid=0 is ignored.
- **Boundary conditions.**
  - A requester dropping valid in the grant cycle is allowed; no grant is made if neither is valid.
  - A requester is never served twice in a row while the other is continuously valid, if RR_EN=1.
  - Wrap-around is modular at 64 and 128 bits.
  - An increment of all-ones yields 0 with carry 1.
- **Implementation.** 120-400 lines of RTL. The state register and datapath registers are updated only on posedge clock.

Test Plan:
- ADD64 from req0, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> rsp_val=0, carry=1, rsp_id=0, rsp_valid 2 cycles after accept.
- SUB64 from req1, a=5, b=7 -> rsp_val[63:0]=0xFFFF_FFFF_FFFF_FFFE, carry=0. Also a=7, b=5 -> 2, carry=1. Latency 3 in both cases.
- ADD128, a=0x0000..0001_FFFF_FFFF_FFFF_FFFF, b=1 -> rsp_val=0x2_0000_0000_0000_0000, carry=0. Latency 4 with HINC taken. Same op with b=0 -> latency 3 when SKIP_HINC=1, 4 when SKIP_HINC=0.
- SUB128, a=0, b=1 -> rsp_val=all ones, carry=0. Check add_a/add_b per state: LO (0, ~1), LINC (lo, 1), HI (0, all-ones), HINC (hi, 0).
- Both requesters continuously valid with RR_EN=1 -> grants alternate 0,1,0,1. With RR_EN=0 -> always 0. Hold rsp_ready=0 for 3 cycles -> rsp_* stable and no new ready.
- Assert reset during the HI pass of a SUB128 -> next cycle all outputs are at reset values and no rsp_valid follows. A subsequent ADD64 completes normally.

Source files
------------

// File: rtl/ex_wideadd_sched.sv
// Wide add/subtract sequencer: time-shares one external 64-bit adder between
// two requesters. 128-bit ops and subtraction are built from several passes
// through the adder (low half, "+1" for two's complement, high half, carry).
module ex_wideadd_sched #(
  parameter bit RR_EN     = 1'b1,
  parameter bit SKIP_HINC = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [127:0] req0_a,
  input  logic [127:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [127:0] req1_a,
  input  logic [127:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_val,
  output logic         rsp_carry,
  output logic [63:0]  add_a,
  output logic [63:0]  add_b,
  input  logic [63:0]  add_c
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_LINC = 3'd2,
    S_HI   = 3'd3,
    S_HINC = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Carry out of one adder pass, recovered from the operand and sum MSBs.
  function automatic logic pass_carry(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] s);
    return (a[63] & b[63]) | ((a[63] | b[63]) & ~s[63]);
  endfunction

  state_t         state_q, state_d;
  logic           rr_q, rr_d;            // id served last
  logic           id_q, id_d;
  logic [1:0]     op_q, op_d;            // op[0]=subtract, op[1]=128-bit
  logic [127:0]   opa_q, opa_d;
  logic [127:0]   opb_q, opb_d;
  logic [63:0]    lo_q, lo_d;            // low-half result
  logic           cin_q, cin_d;          // carry into the high half / 64-bit carry
  logic           chi_q, chi_d;          // carry out of the HI pass
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [127:0]   rsp_val_q, rsp_val_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic [63:0]    add_a_q, add_a_d;
  logic [63:0]    add_b_q, add_b_d;
  logic           gnt0_s, gnt1_s;
  logic           pass_c_s;

  assign pass_c_s   = pass_carry(add_a_q, add_b_q, add_c);
  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_val    = rsp_val_q;
  assign rsp_carry  = rsp_carry_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;

  // Arbitration: only in IDLE; ready is the accept strobe, so it is combinational.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if ((state_q == S_IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN && !rr_q) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0_s = 1'b1;
      end else if (req1_valid) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
    end
  end

  // Sequencer next state, pass results and response capture.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    lo_d        = lo_q;
    cin_d       = cin_q;
    chi_d       = chi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_val_d   = rsp_val_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          id_d    = gnt1_s;
          op_d    = gnt1_s ? req1_op : req0_op;
          opa_d   = gnt1_s ? req1_a : req0_a;
          opb_d   = gnt1_s ? req1_b : req0_b;
          cin_d   = 1'b0;
          chi_d   = 1'b0;
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        lo_d  = add_c;
        cin_d = pass_c_s;
        if (op_q[0]) begin
          state_d = S_LINC;
        end else if (op_q[1]) begin
          state_d = S_HI;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_val_d   = {64'd0, add_c};
          rsp_carry_d = pass_c_s;
        end
      end
      S_LINC: begin
        lo_d  = add_c;
        cin_d = cin_q | pass_c_s;
        if (op_q[1]) begin
          state_d = S_HI;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_val_d   = {64'd0, add_c};
          rsp_carry_d = cin_q | pass_c_s;
        end
      end
      S_HI: begin
        chi_d = pass_c_s;
        if (cin_q || !SKIP_HINC) begin
          state_d = S_HINC;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_val_d   = {add_c, lo_q};
          rsp_carry_d = pass_c_s;
        end
      end
      S_HINC: begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_val_d   = {add_c, lo_q};
        rsp_carry_d = chi_q | pass_c_s;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rr_d        = id_q;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Adder operands for the pass about to start, registered so they are glitch-free.
  always_comb begin
    add_a_d = 64'd0;
    add_b_d = 64'd0;
    case (state_d)
      S_LO: begin
        add_a_d = opa_d[63:0];
        add_b_d = op_d[0] ? ~opb_d[63:0] : opb_d[63:0];
      end
      S_LINC: begin
        add_a_d = add_c;
        add_b_d = 64'd1;
      end
      S_HI: begin
        add_a_d = opa_d[127:64];
        add_b_d = op_d[0] ? ~opb_d[127:64] : opb_d[127:64];
      end
      S_HINC: begin
        add_a_d = add_c;
        add_b_d = {63'd0, cin_d};
      end
      default: begin
        add_a_d = 64'd0;
        add_b_d = 64'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= 2'd0;
      opa_q       <= 128'd0;
      opb_q       <= 128'd0;
      lo_q        <= 64'd0;
      cin_q       <= 1'b0;
      chi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_val_q   <= 128'd0;
      rsp_carry_q <= 1'b0;
      add_a_q     <= 64'd0;
      add_b_q     <= 64'd0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      lo_q        <= lo_d;
      cin_q       <= cin_d;
      chi_q       <= chi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_val_q   <= rsp_val_d;
      rsp_carry_q <= rsp_carry_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

endmodule

// File: tb/tb_ex_wideadd_sched.sv
// Directed bench for ex_wideadd_sched. Instance 0: RR_EN=1, SKIP_HINC=1.
// Instance 1: RR_EN=0, SKIP_HINC=0. Each instance has its own adder model.
module tb_ex_wideadd_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         rst [2];
  logic         v0 [2], v1 [2], rdy0 [2], rdy1 [2];
  logic [1:0]   op0 [2], op1 [2];
  logic [127:0] a0 [2], b0 [2], a1 [2], b1 [2];
  logic         rv [2], rr [2], rid [2], rc [2];
  logic [127:0] rval [2];
  logic [63:0]  aa [2], ab [2], ac [2];
  logic [63:0]  tr_a [8], tr_b [8];
  logic         last [2];

  localparam logic [63:0]  ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] ONES128 = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  assign ac[0] = aa[0] + ab[0];
  assign ac[1] = aa[1] + ab[1];

  ex_wideadd_sched #(.RR_EN(1'b1), .SKIP_HINC(1'b1)) u0 (
    .clock(clk), .reset(rst[0]),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]), .rsp_val(rval[0]), .rsp_carry(rc[0]),
    .add_a(aa[0]), .add_b(ab[0]), .add_c(ac[0]));

  ex_wideadd_sched #(.RR_EN(1'b0), .SKIP_HINC(1'b0)) u1 (
    .clock(clk), .reset(rst[1]),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]), .rsp_val(rval[1]), .rsp_carry(rc[1]),
    .add_a(aa[1]), .add_b(ab[1]), .add_c(ac[1]));

  // Issue one op, check latency/result/id, then complete the handshake.
  task automatic do_op(input int k, input int req, input logic [1:0] op,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] ev, input logic ec, input int elat,
                       input string nm);
    bit acc;
    int lat;
    acc = 1'b0;
    lat = 0;
    @(negedge clk);
    if (req == 0) begin
      v0[k] = 1'b1; op0[k] = op; a0[k] = a; b0[k] = b;
    end else begin
      v1[k] = 1'b1; op1[k] = op; a1[k] = a; b1[k] = b;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (((req == 0) ? rdy0[k] : rdy1[k]) === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s accept: no ready within 20 cycles", nm);
      v0[k] = 1'b0; v1[k] = 1'b0;
      return;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      v0[k] = 1'b0; v1[k] = 1'b0;
      if (n < 8) begin
        tr_a[n] = aa[k];
        tr_b[n] = ab[k];
      end
      if (rv[k] === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== elat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, elat); end
    checks++;
    if (rval[k] !== ev) begin errors++; $display("FAIL %s value: got %h want %h", nm, rval[k], ev); end
    checks++;
    if (rc[k] !== ec) begin errors++; $display("FAIL %s carry: got %b want %b", nm, rc[k], ec); end
    checks++;
    if (rid[k] !== req[0]) begin errors++; $display("FAIL %s id: got %b want %0d", nm, rid[k], req); end
    rr[k] = 1'b1;
    @(negedge clk);
    rr[k] = 1'b0;
    checks++;
    if (rv[k] !== 1'b0) begin errors++; $display("FAIL %s rsp_valid after handshake: got %b want 0", nm, rv[k]); end
    last[k] = req[0];
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; v0[k] = 1'b1; v1[k] = 1'b1; rr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rv[k], rid[k], rc[k], rdy0[k], rdy1[k]} !== 5'b0 || rval[k] !== 128'd0 ||
          aa[k] !== 64'd0 || ab[k] !== 64'd0) begin
        errors++;
        $display("FAIL reset_state u%0d: rv=%b id=%b c=%b rdy=%b%b val=%h a=%h b=%h want all zero",
                 k, rv[k], rid[k], rc[k], rdy0[k], rdy1[k], rval[k], aa[k], ab[k]);
      end
      v0[k] = 1'b0; v1[k] = 1'b0;
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    last[0] = 1'b0; last[1] = 1'b0;
  endtask

  task automatic test_add64();
    do_op(0, 0, 2'd0, {64'd0, ONES64}, 128'd1, 128'd0, 1'b1, 2, "add64_wrap_u0");
    do_op(1, 0, 2'd0, {64'd0, ONES64}, 128'd1, 128'd0, 1'b1, 2, "add64_wrap_u1");
    do_op(1, 1, 2'd0, {64'hDEAD_BEEF_0000_0001, 64'd10}, {64'h1234_0000_0000_0000, 64'd20},
          128'd30, 1'b0, 2, "add64_hi_ignored");
  endtask

  task automatic test_sub64();
    do_op(0, 1, 2'd1, 128'd5, 128'd7, {64'd0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0, 3, "sub64_borrow");
    do_op(0, 1, 2'd1, 128'd7, 128'd5, 128'd2, 1'b1, 3, "sub64_noborrow");
  endtask

  task automatic test_add128();
    do_op(0, 0, 2'd2, {64'd1, ONES64}, 128'd1, {64'd2, 64'd0}, 1'b0, 4, "add128_hinc");
    do_op(0, 0, 2'd2, {64'd1, ONES64}, 128'd0, {64'd1, ONES64}, 1'b0, 3, "add128_skip");
    do_op(1, 0, 2'd2, {64'd1, ONES64}, 128'd0, {64'd1, ONES64}, 1'b0, 4, "add128_noskip");
    do_op(0, 1, 2'd2, ONES128, 128'd1, 128'd0, 1'b1, 4, "add128_wrap");
  endtask

  task automatic test_sub128();
    do_op(1, 0, 2'd3, 128'd0, 128'd1, ONES128, 1'b0, 5, "sub128_u1");
    checks++;
    if (tr_a[1] !== 64'd0 || tr_b[1] !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL sub128 LO drive: got a=%h b=%h want 0 / fffffffffffffffe", tr_a[1], tr_b[1]);
    end
    checks++;
    if (tr_a[2] !== 64'hFFFF_FFFF_FFFF_FFFE || tr_b[2] !== 64'd1) begin
      errors++; $display("FAIL sub128 LINC drive: got a=%h b=%h want fffffffffffffffe / 1", tr_a[2], tr_b[2]);
    end
    checks++;
    if (tr_a[3] !== 64'd0 || tr_b[3] !== ONES64) begin
      errors++; $display("FAIL sub128 HI drive: got a=%h b=%h want 0 / ffffffffffffffff", tr_a[3], tr_b[3]);
    end
    checks++;
    if (tr_a[4] !== ONES64 || tr_b[4] !== 64'd0) begin
      errors++; $display("FAIL sub128 HINC drive: got a=%h b=%h want ffffffffffffffff / 0", tr_a[4], tr_b[4]);
    end
    do_op(0, 0, 2'd3, 128'd0, 128'd1, ONES128, 1'b0, 4, "sub128_u0");
  endtask

  // Response held for 3 cycles with rsp_ready low while req1 waits.
  task automatic test_hold();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    v0[0] = 1'b1; op0[0] = 2'd0; a0[0] = 128'd3; b0[0] = 128'd4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v0[0] = 1'b0;
      if (rv[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL hold: rsp_valid never rose"); end
    v1[0] = 1'b1; op1[0] = 2'd0; a1[0] = 128'd1; b1[0] = 128'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rv[0] !== 1'b1 || rval[0] !== 128'd7 || rc[0] !== 1'b0 || rid[0] !== 1'b0 ||
          rdy0[0] !== 1'b0 || rdy1[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: rv=%b val=%h c=%b id=%b rdy=%b%b want 1/7/0/0/00",
                 i, rv[0], rval[0], rc[0], rid[0], rdy0[0], rdy1[0]);
      end
      @(negedge clk);
    end
    v1[0] = 1'b0;
    rr[0] = 1'b1;
    @(negedge clk);
    rr[0] = 1'b0;
    last[0] = 1'b0;
  endtask

  // Both requesters continuously valid; record the first four grants.
  task automatic test_rr(input int k);
    logic g [4];
    int   cnt;
    logic expv;
    cnt = 0;
    @(negedge clk);
    v0[k] = 1'b1; op0[k] = 2'd0; a0[k] = 128'd1; b0[k] = 128'd2;
    v1[k] = 1'b1; op1[k] = 2'd0; a1[k] = 128'd3; b1[k] = 128'd4;
    rr[k] = 1'b1;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      #1;
      if (rdy0[k] === 1'b1 && rdy1[k] === 1'b1) begin
        checks++; errors++;
        $display("FAIL rr_u%0d double ready: got 11 want one-hot", k);
      end else if (rdy0[k] === 1'b1) begin
        g[cnt] = 1'b0; cnt++;
      end else if (rdy1[k] === 1'b1) begin
        g[cnt] = 1'b1; cnt++;
      end
      @(negedge clk);
    end
    v0[k] = 1'b0; v1[k] = 1'b0;
    repeat (6) @(negedge clk);
    rr[k] = 1'b0;
    checks++;
    if (cnt != 4) begin
      errors++; $display("FAIL rr_u%0d grant count: got %0d want 4", k, cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        expv = (k == 0) ? (((i % 2) == 0) ? ~last[k] : last[k]) : 1'b0;
        checks++;
        if (g[i] !== expv) begin
          errors++; $display("FAIL rr_u%0d grant %0d: got %b want %b", k, i, g[i], expv);
        end
      end
      last[k] = g[3];
    end
  endtask

  // Reset during the HI pass of a SUB128; no response may follow.
  task automatic test_reset_mid();
    bit spurious;
    spurious = 1'b0;
    @(negedge clk);
    v0[0] = 1'b1; op0[0] = 2'd3; a0[0] = 128'd0; b0[0] = 128'd1;
    #1;
    checks++;
    if (rdy0[0] !== 1'b1) begin errors++; $display("FAIL reset_mid accept: got %b want 1", rdy0[0]); end
    repeat (3) @(negedge clk);
    v0[0] = 1'b0;
    checks++;
    if (aa[0] !== 64'd0 || ab[0] !== ONES64) begin
      errors++; $display("FAIL reset_mid HI drive: got a=%h b=%h want 0 / ffffffffffffffff", aa[0], ab[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({rv[0], rid[0], rc[0], rdy0[0], rdy1[0]} !== 5'b0 || rval[0] !== 128'd0 ||
        aa[0] !== 64'd0 || ab[0] !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: rv=%b id=%b c=%b val=%h a=%h b=%h want all zero",
               rv[0], rid[0], rc[0], rval[0], aa[0], ab[0]);
    end
    rst[0] = 1'b0;
    last[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv[0] !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin errors++; $display("FAIL reset_mid spurious rsp_valid: got 1 want 0"); end
    do_op(0, 0, 2'd0, 128'd100, 128'd23, 128'd123, 1'b0, 2, "add64_after_reset");
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b0;
      op0[k] = 2'd0; op1[k] = 2'd0;
      a0[k] = 128'd0; b0[k] = 128'd0; a1[k] = 128'd0; b1[k] = 128'd0;
      last[k] = 1'b0;
    end
    test_reset();
    test_add64();
    test_sub64();
    test_add128();
    test_sub128();
    test_hold();
    test_rr(0);
    test_rr(1);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
